// File: rtl/vga_pkg.sv
// Shared VGA timing constants for the 640x480 active display area.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;  // columns
  localparam int unsigned V_ACTIVE = 480;  // rows
  localparam int unsigned X_BITS   = 9;    // row position width
  localparam int unsigned Y_BITS   = 10;   // column position width
  localparam int unsigned W_BITS   = 6;    // border thickness width
  localparam int unsigned CMP_BITS = 11;   // compare width, wide enough for limit - W

endpackage

// File: rtl/frame_detect_if.sv
// Raster position / border flag bundle between the VGA counters and the colour mux.
interface frame_detect_if
  import vga_pkg::*;
#(
  parameter int unsigned X_BITS = vga_pkg::X_BITS,
  parameter int unsigned Y_BITS = vga_pkg::Y_BITS,
  parameter int unsigned W_BITS = vga_pkg::W_BITS
);

  logic [X_BITS-1:0] x_pos;     // row
  logic [Y_BITS-1:0] y_pos;     // column
  logic [W_BITS-1:0] W;         // border thickness
  logic              detected;
  logic              top;
  logic              bottom;
  logic              left;
  logic              right;
  logic              corner;

  modport master (
    output x_pos, y_pos, W,
    input  detected, top, bottom, left, right, corner
  );

  modport slave (
    input  x_pos, y_pos, W,
    output detected, top, bottom, left, right, corner
  );

endinterface

// File: rtl/frame_detect_edge_band_check.sv
// Flags a position lying within W of either end of a 0..limit-1 range.
module edge_band_check
  import vga_pkg::*;
#(
  parameter int unsigned POS_BITS = vga_pkg::X_BITS,
  parameter int unsigned W_BITS   = vga_pkg::W_BITS,
  parameter int unsigned CMP_BITS = vga_pkg::CMP_BITS
) (
  input  logic [POS_BITS-1:0] i_pos,
  input  logic [W_BITS-1:0]   i_w,
  input  logic [CMP_BITS-1:0] i_limit,
  output logic                o_low,
  output logic                o_high
);

  logic [CMP_BITS-1:0] w_pos;
  logic [CMP_BITS-1:0] w_w;
  logic [CMP_BITS-1:0] w_thresh;

  // Low band: pos < W; high band: pos >= limit - W (limit always exceeds max W).
  always_comb begin
    w_pos    = CMP_BITS'(i_pos);
    w_w      = CMP_BITS'(i_w);
    w_thresh = i_limit - w_w;
    o_low    = (w_pos < w_w);
    o_high   = (w_pos >= w_thresh);
  end

endmodule

// File: rtl/frame_detect.sv
// Per-pixel border detector: registers edge/corner flags for a W-thick frame.
module frame_detect
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned W_BITS   = vga_pkg::W_BITS
) (
  input logic           clk,
  input logic           rst,
  frame_detect_if.slave bus
);

  logic w_row_low, w_row_high, w_col_low, w_col_high;
  logic w_valid;
  logic w_top, w_bottom, w_left, w_right;
  logic w_detected, w_corner;

  logic r_detected, r_top, r_bottom, r_left, r_right, r_corner;

  edge_band_check #(
    .POS_BITS (X_BITS),
    .W_BITS   (W_BITS),
    .CMP_BITS (CMP_BITS)
  ) u_rows (
    .i_pos   (bus.x_pos),
    .i_w     (bus.W),
    .i_limit (CMP_BITS'(V_ACTIVE)),
    .o_low   (w_row_low),
    .o_high  (w_row_high)
  );

  edge_band_check #(
    .POS_BITS (Y_BITS),
    .W_BITS   (W_BITS),
    .CMP_BITS (CMP_BITS)
  ) u_cols (
    .i_pos   (bus.y_pos),
    .i_w     (bus.W),
    .i_limit (CMP_BITS'(H_ACTIVE)),
    .o_low   (w_col_low),
    .o_high  (w_col_high)
  );

  // Qualify edge bands with position validity so off-screen positions never flag.
  always_comb begin
    w_valid    = (CMP_BITS'(bus.x_pos) < CMP_BITS'(V_ACTIVE)) &&
                 (CMP_BITS'(bus.y_pos) < CMP_BITS'(H_ACTIVE));
    w_top      = w_valid & w_row_low;
    w_bottom   = w_valid & w_row_high;
    w_left     = w_valid & w_col_low;
    w_right    = w_valid & w_col_high;
    w_detected = w_top | w_bottom | w_left | w_right;
    w_corner   = (w_top | w_bottom) & (w_left | w_right);
  end

  // Output registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_detected <= 1'b0;
      r_top      <= 1'b0;
      r_bottom   <= 1'b0;
      r_left     <= 1'b0;
      r_right    <= 1'b0;
      r_corner   <= 1'b0;
    end else begin
      r_detected <= w_detected;
      r_top      <= w_top;
      r_bottom   <= w_bottom;
      r_left     <= w_left;
      r_right    <= w_right;
      r_corner   <= w_corner;
    end
  end

  assign bus.detected = r_detected;
  assign bus.top      = r_top;
  assign bus.bottom   = r_bottom;
  assign bus.left     = r_left;
  assign bus.right    = r_right;
  assign bus.corner   = r_corner;

endmodule

// File: tb/tb_frame_detect.sv
// Scoreboard bench for frame_detect: driver pushes expected flags, monitor pops/compares.
module tb_frame_detect;

  logic clk;
  logic rst;

  frame_detect_if bus ();

  frame_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flag order: {detected, top, bottom, left, right, corner}
  typedef struct {
    logic [5:0] exp;
    int         x;
    int         y;
    int         w;
  } item_t;

  item_t sb_q[$];
  int    checks   = 0;
  int    failures = 0;

  function automatic logic [5:0] model(int x, int y, int w);
    bit v, t, b, l, r;
    v = (x < 480) && (y < 640);
    t = v && (x < w);
    b = v && (x >= 480 - w);
    l = v && (y < w);
    r = v && (y >= 640 - w);
    return {t | b | l | r, t, b, l, r, (t | b) & (l | r)};
  endfunction

  function automatic logic [5:0] flags();
    return {bus.detected, bus.top, bus.bottom, bus.left, bus.right, bus.corner};
  endfunction

  // Drive one position with a hand-computed expectation.
  task automatic apply_exp(int x, int y, int w, logic [5:0] exp);
    item_t it;
    @(negedge clk);
    bus.x_pos = 9'(x);
    bus.y_pos = 10'(y);
    bus.W     = 6'(w);
    it.exp = exp; it.x = x; it.y = y; it.w = w;
    sb_q.push_back(it);
  endtask

  // Drive one position with the reference-model expectation.
  task automatic apply(int x, int y, int w);
    apply_exp(x, y, w, model(x, y, w));
  endtask

  task automatic check_now(string name, logic [5:0] exp);
    checks++;
    if (flags() !== exp) begin
      failures++;
      $display("FAIL %s got=%b required=%b", name, flags(), exp);
    end
  endtask

  // Monitor: outputs are valid one cycle after capture; compare shortly after each edge.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() != 0) begin
      item_t it;
      it = sb_q.pop_front();
      checks++;
      if (flags() !== it.exp) begin
        failures++;
        $display("FAIL flags x=%0d y=%0d W=%0d got=%b required=%b",
                 it.x, it.y, it.w, flags(), it.exp);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    bus.x_pos = '0;
    bus.y_pos = '0;
    bus.W     = '0;
    #1;
    check_now("reset_state", 6'b000000);
    @(negedge clk);
    rst = 1'b0;

    // Top / bottom rows at W=10
    apply_exp(0,   300, 10, 6'b110000);
    apply_exp(9,   300, 10, 6'b110000);
    apply_exp(10,  300, 10, 6'b000000);
    apply_exp(469, 300, 10, 6'b000000);
    apply_exp(470, 300, 10, 6'b101000);
    apply_exp(479, 300, 10, 6'b101000);
    // Left / right columns at W=10
    apply_exp(200, 9,   10, 6'b100100);
    apply_exp(200, 10,  10, 6'b000000);
    apply_exp(200, 629, 10, 6'b000000);
    apply_exp(200, 630, 10, 6'b100010);
    apply_exp(200, 639, 10, 6'b100010);
    // Corners
    apply_exp(0,   0,   10, 6'b110101);
    apply_exp(479, 639, 63, 6'b101011);
    // W=63 boundaries
    apply_exp(62,  300, 63, 6'b110000);
    apply_exp(63,  300, 63, 6'b000000);
    apply_exp(416, 300, 63, 6'b000000);
    apply_exp(417, 300, 63, 6'b101000);
    apply_exp(100, 62,  63, 6'b100100);
    apply_exp(100, 576, 63, 6'b000000);
    apply_exp(100, 577, 63, 6'b100010);
    // Out of range and W=0 at invalid positions
    apply_exp(500, 300, 10, 6'b000000);
    apply_exp(200, 700, 10, 6'b000000);
    apply_exp(480, 0,   0,  6'b000000);
    apply_exp(0,   640, 0,  6'b000000);
    apply_exp(480, 640, 63, 6'b000000);
    apply_exp(0,   0,   0,  6'b000000);
    // Live W change takes effect on the next cycle
    apply_exp(5,   300, 10, 6'b110000);
    apply_exp(5,   300, 4,  6'b000000);

    // W=0 sweep along the screen edges: nothing may flag
    for (int x = 0; x < 480; x++) begin
      apply_exp(x, 0,   0, 6'b000000);
      apply_exp(x, 639, 0, 6'b000000);
    end
    for (int y = 0; y < 640; y++) begin
      apply_exp(0,   y, 0, 6'b000000);
      apply_exp(479, y, 0, 6'b000000);
    end

    // W=10 raster slices against the reference model
    for (int x = 0; x < 480; x++) begin
      apply(x, 0,   10); apply(x, 9,   10); apply(x, 10,  10);
      apply(x, 320, 10); apply(x, 629, 10); apply(x, 630, 10);
      apply(x, 639, 10);
    end
    for (int y = 0; y < 640; y++) begin
      apply(0,   y, 10); apply(9,   y, 10); apply(10,  y, 10);
      apply(240, y, 10); apply(469, y, 10); apply(470, y, 10);
      apply(479, y, 10);
    end

    // Asynchronous reset mid-raster while detected=1
    apply_exp(0, 0, 10, 6'b110101);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_now("async_reset_drop", 6'b000000);
    @(posedge clk);
    #1;
    check_now("reset_hold", 6'b000000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_now("reset_release_no_edge", 6'b000000);
    @(posedge clk);
    #3;
    check_now("reset_release_first_edge", 6'b110101);

    apply_exp(470, 630, 10, 6'b101011);
    apply_exp(240, 320, 10, 6'b000000);

    // Bounded drain of pending expectations
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #3;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
